// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional macro: SERIAL_SUBTRACTOR_OVERFLOW_EN adds the signed overflow output.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_behave.sv
// One-bit full subtractor: diff = a - b - bin, with borrow out.
module full_subtractor_behave (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    always_comb begin
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~a & bin) | (b & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Optional macro: SERIAL_SUBTRACTOR_OVERFLOW_EN adds ovf_out (signed overflow).
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_out,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    output logic             ovf_out,
`endif
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_borrow_out;
    logic             w_accept;
    logic             w_last;
    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_diff;
    logic             w_bout;

    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_cnt == LAST);
    assign w_a_bit  = r_a[r_cnt];
    assign w_b_bit  = r_b[r_cnt];

    full_subtractor_behave u_fs (
        .a    (w_a_bit),
        .b    (w_b_bit),
        .bin  (r_borrow),
        .diff (w_diff),
        .bout (w_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = start ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operands stay put during SHIFT; the counter selects the bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a_in;
            r_b      <= b_in;
            r_res    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_borrow <= w_bout;
            r_res    <= {w_diff, r_res[WIDTH-1:1]};
            if (w_last) begin
                r_diff       <= {w_diff, r_res[WIDTH-1:1]};
                r_borrow_out <= w_bout;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic r_ovf;

    // On the last bit the counter points at the MSB of both operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (!w_accept && r_state == SHIFT && w_last) begin
            r_ovf <= (w_a_bit != w_b_bit) && (w_diff != w_a_bit);
        end
    end

    assign ovf_out = r_ovf;
`endif

    assign busy       = (r_state == SHIFT);
    assign done       = (r_state == DONE);
    assign diff_out   = r_diff;
    assign borrow_out = r_borrow_out;

endmodule
